ctrl_pkt_inject: RTL and testbench

Builds reconfiguration control packets for the RMT pipeline from a simple command interface and merges them into the ingress AXI-Stream ahead of the packet filter. It is the transmit end of the control-packet protocol that the filter extracts and forwards along the parser, stage and deparser control chain. Data packets pass through untouched. Control and data packets alternate at packet boundaries.

---
 rtl/ctrl_pkt_inject.sv | 234 +++++++++++++++++++++++
 tb/tb_ctrl_pkt_inject.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pkt_inject.sv
// Merges reconfiguration control packets, built from a command interface, into the
// ingress AXI-Stream. Control and data packets are interleaved at packet boundaries.
module ctrl_pkt_inject #(
   parameter int          C_S_AXIS_DATA_WIDTH  = 512,
   parameter int          C_S_AXIS_TUSER_WIDTH = 128,
   parameter logic [47:0] DST_MAC              = 48'h0,
   parameter logic [47:0] SRC_MAC              = 48'h0,
   parameter logic [11:0] CTRL_VLAN_ID         = 12'h0,
   parameter logic [15:0] CTRL_UDP_PORT        = 16'hf1f2,
   parameter logic [7:0]  CTRL_SRC_PORT        = 8'h0
) (
   input  logic                              clk,
   input  logic                              aresetn,
   input  logic [31:0]                       ctrl_token,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic [7:0]                        cmd_mod_id,
   input  logic [7:0]                        cmd_index,
   input  logic [6:0]                        cmd_len,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    cmd_payload,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   input  logic                              s_axis_tlast,
   output logic                              s_axis_tready,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   output logic                              m_axis_tlast,
   input  logic                              m_axis_tready,
   output logic [31:0]                       ctrl_sent_cnt
);

   localparam int DW = C_S_AXIS_DATA_WIDTH;
   localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
   localparam int TW = C_S_AXIS_TUSER_WIDTH;

   typedef enum logic [1:0] {IDLE, DATA, CTRL_HDR, CTRL_PAY} state_t;

   state_t          state_reg, state_next;
   logic            last_ctrl_reg, last_ctrl_next;
   logic            run_reg;
   logic [7:0]      seq_reg, seq_next;
   logic [31:0]     cnt_reg, cnt_next;
   logic [6:0]      len_reg, len_next;
   logic [DW-1:0]   payload_reg, payload_next;
   logic [DW-1:0]   tdata_reg, tdata_next;
   logic [KW-1:0]   tkeep_reg, tkeep_next;
   logic [TW-1:0]   tuser_reg, tuser_next;
   logic            tvalid_reg, tvalid_next;
   logic            tlast_reg, tlast_next;

   logic            out_slot_free;
   logic            grant_ctrl;
   logic            grant_data;
   logic            cmd_ready_c;
   logic            s_ready_c;
   logic [6:0]      len_in;
   logic [DW-1:0]   pay_data;
   logic [KW-1:0]   pay_keep;

   assign out_slot_free = !tvalid_reg || m_axis_tready;
   assign len_in        = (cmd_len == 7'd0 || cmd_len > 7'd64) ? 7'd64 : cmd_len;
   // run_reg keeps both handshakes low on the first cycle out of reset
   assign grant_ctrl    = run_reg && cmd_valid && (!s_axis_tvalid || !last_ctrl_reg);
   assign grant_data    = run_reg && s_axis_tvalid && !grant_ctrl;

   function automatic logic [TW-1:0] ctrl_user(input logic [6:0] l);
      logic [TW-1:0] u;
      u        = '0;
      u[15:0]  = 16'd64 + {9'd0, l};
      u[23:16] = CTRL_SRC_PORT;
      return u;
   endfunction

   function automatic logic [DW-1:0] build_hdr(input logic [31:0] token, input logic [7:0] mod_id,
                                               input logic [7:0] index, input logic [6:0] l,
                                               input logic [7:0] seq);
      logic [DW-1:0] h;
      logic [15:0]   ip_len;
      logic [15:0]   udp_len;
      h       = '0;
      ip_len  = 16'd46 + {9'd0, l};
      udp_len = 16'd26 + {9'd0, l};
      for (int i = 0; i < 6; i++) begin
         h[8*i +: 8]     = DST_MAC[8*(5-i) +: 8];
         h[8*(6+i) +: 8] = SRC_MAC[8*(5-i) +: 8];
      end
      h[8*12 +: 8] = 8'h81;
      h[8*13 +: 8] = 8'h00;
      h[8*14 +: 8] = {4'h0, CTRL_VLAN_ID[11:8]};
      h[8*15 +: 8] = CTRL_VLAN_ID[7:0];
      h[8*16 +: 8] = 8'h08;
      h[8*17 +: 8] = 8'h00;
      h[8*18 +: 8] = 8'h45;
      h[8*19 +: 8] = 8'h00;
      h[8*20 +: 8] = ip_len[15:8];
      h[8*21 +: 8] = ip_len[7:0];
      h[8*24 +: 8] = 8'h40;
      h[8*26 +: 8] = 8'h40;
      h[8*27 +: 8] = 8'h11;
      h[8*38 +: 8] = CTRL_UDP_PORT[15:8];
      h[8*39 +: 8] = CTRL_UDP_PORT[7:0];
      h[8*40 +: 8] = CTRL_UDP_PORT[15:8];
      h[8*41 +: 8] = CTRL_UDP_PORT[7:0];
      h[8*42 +: 8] = udp_len[15:8];
      h[8*43 +: 8] = udp_len[7:0];
      h[8*46 +: 8] = token[31:24];
      h[8*47 +: 8] = token[23:16];
      h[8*48 +: 8] = token[15:8];
      h[8*49 +: 8] = token[7:0];
      h[8*50 +: 8] = mod_id;
      h[8*51 +: 8] = index;
      h[8*52 +: 8] = {1'b0, l};
      h[8*53 +: 8] = seq;
      return h;
   endfunction

   for (genvar gi = 0; gi < KW; gi++) begin : g_pay
      assign pay_keep[gi]          = (32'(len_reg) > gi);
      assign pay_data[8*gi +: 8]   = pay_keep[gi] ? payload_reg[8*gi +: 8] : 8'h00;
   end

   always_comb begin
      state_next     = state_reg;
      last_ctrl_next = last_ctrl_reg;
      seq_next       = seq_reg;
      cnt_next       = cnt_reg;
      len_next       = len_reg;
      payload_next   = payload_reg;
      tdata_next     = tdata_reg;
      tkeep_next     = tkeep_reg;
      tuser_next     = tuser_reg;
      tlast_next     = tlast_reg;
      tvalid_next    = tvalid_reg && !out_slot_free;
      cmd_ready_c    = 1'b0;
      s_ready_c      = 1'b0;
      case (state_reg)
         IDLE: begin
            // The header is loaded on the handshake so beat 0 is valid the next cycle
            if (grant_ctrl) begin
               if (out_slot_free) begin
                  cmd_ready_c  = 1'b1;
                  len_next     = len_in;
                  payload_next = cmd_payload;
                  tdata_next   = build_hdr(ctrl_token, cmd_mod_id, cmd_index, len_in, seq_reg);
                  tkeep_next   = '1;
                  tuser_next   = ctrl_user(len_in);
                  tlast_next   = 1'b0;
                  tvalid_next  = 1'b1;
                  state_next   = CTRL_HDR;
               end
            end else if (grant_data) begin
               state_next = DATA;
            end
         end
         DATA: begin
            s_ready_c = out_slot_free;
            if (s_axis_tvalid && out_slot_free) begin
               tdata_next  = s_axis_tdata;
               tkeep_next  = s_axis_tkeep;
               tuser_next  = s_axis_tuser;
               tlast_next  = s_axis_tlast;
               tvalid_next = 1'b1;
               if (s_axis_tlast) begin
                  state_next     = IDLE;
                  last_ctrl_next = 1'b0;
               end
            end
         end
         CTRL_HDR: begin
            if (out_slot_free) begin
               tdata_next  = pay_data;
               tkeep_next  = pay_keep;
               tuser_next  = ctrl_user(len_reg);
               tlast_next  = 1'b1;
               tvalid_next = 1'b1;
               state_next  = CTRL_PAY;
            end
         end
         CTRL_PAY: begin
            if (out_slot_free) begin
               state_next     = IDLE;
               last_ctrl_next = 1'b1;
               seq_next       = seq_reg + 8'd1;
               cnt_next       = cnt_reg + 32'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_reg     <= IDLE;
         last_ctrl_reg <= 1'b0;
         run_reg       <= 1'b0;
         seq_reg       <= 8'd0;
         cnt_reg       <= 32'd0;
         len_reg       <= 7'd0;
         payload_reg   <= '0;
         tdata_reg     <= '0;
         tkeep_reg     <= '0;
         tuser_reg     <= '0;
         tvalid_reg    <= 1'b0;
         tlast_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         last_ctrl_reg <= last_ctrl_next;
         run_reg       <= 1'b1;
         seq_reg       <= seq_next;
         cnt_reg       <= cnt_next;
         len_reg       <= len_next;
         payload_reg   <= payload_next;
         tdata_reg     <= tdata_next;
         tkeep_reg     <= tkeep_next;
         tuser_reg     <= tuser_next;
         tvalid_reg    <= tvalid_next;
         tlast_reg     <= tlast_next;
      end
   end

   assign cmd_ready     = cmd_ready_c;
   assign s_axis_tready = s_ready_c;
   assign m_axis_tdata  = tdata_reg;
   assign m_axis_tkeep  = tkeep_reg;
   assign m_axis_tuser  = tuser_reg;
   assign m_axis_tvalid = tvalid_reg;
   assign m_axis_tlast  = tlast_reg;
   assign ctrl_sent_cnt = cnt_reg;

endmodule

// File: tb/tb_ctrl_pkt_inject.sv
// Directed bench for ctrl_pkt_inject: command vector table plus sequences for
// arbitration, backpressure, sequence wrap and mid-packet reset.
module tb_ctrl_pkt_inject;

   logic          clk = 1'b0;
   logic          aresetn = 1'b0;
   logic [31:0]   ctrl_token = '0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [7:0]    cmd_mod_id = '0;
   logic [7:0]    cmd_index = '0;
   logic [6:0]    cmd_len = '0;
   logic [511:0]  cmd_payload = '0;
   logic [511:0]  s_tdata = '0;
   logic [63:0]   s_tkeep = '0;
   logic [127:0]  s_tuser = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tlast = 1'b0;
   logic          s_tready;
   logic [511:0]  m_tdata;
   logic [63:0]   m_tkeep;
   logic [127:0]  m_tuser;
   logic          m_tvalid;
   logic          m_tlast;
   logic          m_tready = 1'b1;
   logic [31:0]   sent_cnt;

   int            checks = 0;
   int            failures = 0;
   int            tr_mode = 0;

   always #5 clk = ~clk;

   ctrl_pkt_inject #(
      .C_S_AXIS_DATA_WIDTH (512),
      .C_S_AXIS_TUSER_WIDTH(128),
      .DST_MAC             (48'h001122334455),
      .SRC_MAC             (48'ha0a1a2a3a4a5),
      .CTRL_VLAN_ID        (12'h123),
      .CTRL_UDP_PORT       (16'hf1f2),
      .CTRL_SRC_PORT       (8'h5a)
   ) dut (
      .clk          (clk),
      .aresetn      (aresetn),
      .ctrl_token   (ctrl_token),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_mod_id   (cmd_mod_id),
      .cmd_index    (cmd_index),
      .cmd_len      (cmd_len),
      .cmd_payload  (cmd_payload),
      .s_axis_tdata (s_tdata),
      .s_axis_tkeep (s_tkeep),
      .s_axis_tuser (s_tuser),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tlast (s_tlast),
      .s_axis_tready(s_tready),
      .m_axis_tdata (m_tdata),
      .m_axis_tkeep (m_tkeep),
      .m_axis_tuser (m_tuser),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tlast (m_tlast),
      .m_axis_tready(m_tready),
      .ctrl_sent_cnt(sent_cnt)
   );

   typedef struct {
      logic [7:0]  mod;
      logic [7:0]  idx;
      logic [6:0]  len;
      logic [63:0] pay;
      logic [31:0] token;
      logic [7:0]  exp_l;
      logic [63:0] exp_keep;
      logic [63:0] exp_lo;
      logic        exp_hi_ones;
      logic [15:0] exp_tuser;
      logic [15:0] exp_iplen;
      logic [15:0] exp_udplen;
   } vec_t;

   vec_t vecs[5];

   logic [511:0] q_data[$];
   logic [63:0]  q_keep[$];
   logic [127:0] q_user[$];
   logic         q_last[$];

   logic         stall_prev = 1'b0;
   logic [511:0] hold_data;
   logic [63:0]  hold_keep;
   logic [127:0] hold_user;
   logic         hold_last;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] bt(input logic [511:0] d, input int n);
      return d[8*n +: 8];
   endfunction

   function automatic logic [511:0] mk_data(input int pid, input int b);
      logic [31:0] w;
      w = 32'hd000_0000 | 32'(pid << 8) | 32'(b);
      return {16{w}};
   endfunction

   // tready pattern: 0 = always ready, 1 = toggle every cycle, 2 = never ready
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (tr_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'b0;
         endcase
      end
   end

   // Collects accepted output beats and checks that stalled outputs hold still
   always @(negedge clk) begin
      if (!aresetn) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev)
            chk("stall_hold", 64'(m_tvalid && m_tdata === hold_data && m_tkeep === hold_keep &&
                                  m_tuser === hold_user && m_tlast === hold_last), 64'd1);
         if (m_tvalid && m_tready) begin
            q_data.push_back(m_tdata);
            q_keep.push_back(m_tkeep);
            q_user.push_back(m_tuser);
            q_last.push_back(m_tlast);
         end
         stall_prev = m_tvalid && !m_tready;
         hold_data  = m_tdata;
         hold_keep  = m_tkeep;
         hold_user  = m_tuser;
         hold_last  = m_tlast;
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic pop(output logic [511:0] d, output logic [63:0] k, output logic [127:0] u,
                      output logic l);
      d = q_data.pop_front();
      k = q_keep.pop_front();
      u = q_user.pop_front();
      l = q_last.pop_front();
   endtask

   task automatic wait_beats(input int n, input string name);
      int cyc = 0;
      while (q_data.size() < n && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      chk(name, 64'(q_data.size() >= n), 64'd1);
   endtask

   task automatic send_cmd(input vec_t v, output logic hdr_ok);
      int cyc = 0;
      cmd_mod_id  = v.mod;
      cmd_index   = v.idx;
      cmd_len     = v.len;
      cmd_payload = {{448{1'b1}}, v.pay};
      ctrl_token  = v.token;
      cmd_valid   = 1'b1;
      @(negedge clk);
      while (!cmd_ready && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      if (!cmd_ready) begin
         chk("cmd_handshake_timeout", 64'd0, 64'd1);
         cmd_valid = 1'b0;
         hdr_ok    = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      cmd_valid  = 1'b0;
      ctrl_token = 32'h0;
      hdr_ok     = m_tvalid && (bt(m_tdata, 12) == 8'h81);
   endtask

   task automatic send_data(input int pid, input int nbeats);
      for (int b = 0; b < nbeats; b++) begin
         int cyc = 0;
         s_tdata  = mk_data(pid, b);
         s_tkeep  = (b == nbeats - 1) ? 64'h0f : '1;
         s_tuser  = {96'h0, 32'hab00_0000 | 32'(pid << 8) | 32'(b)};
         s_tlast  = (b == nbeats - 1);
         s_tvalid = 1'b1;
         @(negedge clk);
         while (!s_tready && cyc < 1000) begin
            @(negedge clk);
            cyc++;
         end
         if (!s_tready) begin
            chk("data_ready_timeout", 64'd0, 64'd1);
            break;
         end
         @(posedge clk);
         #1;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic check_ctrl_pkt(input vec_t v, input logic [7:0] seq);
      logic [511:0] d;
      logic [63:0]  k;
      logic [127:0] u;
      logic         l;
      wait_beats(2, "ctrl_beats");
      if (q_data.size() < 2) return;
      pop(d, k, u, l);
      chk("hdr_eth", {bt(d,0), bt(d,5), bt(d,6), bt(d,11), bt(d,12), bt(d,13), bt(d,14), bt(d,15)},
          64'h0055a0a581000123);
      chk("hdr_ip", {bt(d,16), bt(d,17), bt(d,18), bt(d,19), bt(d,20), bt(d,21), bt(d,26), bt(d,27)},
          {8'h08, 8'h00, 8'h45, 8'h00, v.exp_iplen, 8'h40, 8'h11});
      chk("hdr_ipz", {bt(d,22), bt(d,23), bt(d,24), bt(d,25), bt(d,28), bt(d,29), bt(d,30), bt(d,31)},
          64'h0000400000000000);
      chk("hdr_udp", {bt(d,38), bt(d,39), bt(d,40), bt(d,41), bt(d,42), bt(d,43), bt(d,44), bt(d,45)},
          {16'hf1f2, 16'hf1f2, v.exp_udplen, 16'h0000});
      chk("hdr_token", {32'h0, bt(d,46), bt(d,47), bt(d,48), bt(d,49)}, {32'h0, v.token});
      chk("hdr_ctl", {32'h0, bt(d,50), bt(d,51), bt(d,52), bt(d,53)}, {32'h0, v.mod, v.idx, v.exp_l, seq});
      chk("hdr_tail_zero", 64'(d[511:432] == 80'h0), 64'd1);
      chk("hdr_keep", k, '1);
      chk("hdr_last", 64'(l), 64'd0);
      chk("hdr_tuser", u[63:0], {40'h0, 8'h5a, v.exp_tuser});
      chk("hdr_tuser_hi", u[127:64], 64'h0);
      pop(d, k, u, l);
      chk("pay_lo", d[63:0], v.exp_lo);
      chk("pay_hi", 64'(d[511:64] == (v.exp_hi_ones ? {448{1'b1}} : 448'h0)), 64'd1);
      chk("pay_keep", k, v.exp_keep);
      chk("pay_last", 64'(l), 64'd1);
      chk("pay_tuser", u[63:0], {40'h0, 8'h5a, v.exp_tuser});
      $display("CTRL mod=%02h idx=%02h L=%0d seq=%0d", v.mod, v.idx, v.exp_l, seq);
   endtask

   initial begin
      logic         hdr_ok;
      logic [511:0] d;
      logic [63:0]  k;
      logic [127:0] u;
      logic         l;
      logic         is_ctrl;

      vecs[0] = '{8'h03, 8'h10, 7'd8,   64'h0807060504030201, 32'hdeadbeef, 8'd8,
                  64'hff, 64'h0807060504030201, 1'b0, 16'd72, 16'd54, 16'd34};
      vecs[1] = '{8'h0a, 8'h01, 7'd0,   64'h1122, 32'h01020304, 8'd64,
                  '1, 64'h1122, 1'b1, 16'd128, 16'd110, 16'd90};
      vecs[2] = '{8'h0b, 8'h02, 7'd100, 64'h33, 32'h55aa55aa, 8'd64,
                  '1, 64'h33, 1'b1, 16'd128, 16'd110, 16'd90};
      vecs[3] = '{8'h0c, 8'hff, 7'd1,   64'hffa5, 32'h12345678, 8'd1,
                  64'h1, 64'ha5, 1'b0, 16'd65, 16'd47, 16'd27};
      vecs[4] = '{8'h0d, 8'h20, 7'd64,  64'hcafe, 32'h0badf00d, 8'd64,
                  '1, 64'hcafe, 1'b1, 16'd128, 16'd110, 16'd90};

      // Reset state, with both requesters asserted to expose any leaking handshake
      cmd_valid = 1'b1;
      s_tvalid  = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_tdata", 64'(m_tdata == 512'h0), 64'd1);
      chk("rst_tkeep_tlast", {m_tkeep[62:0], m_tlast}, 64'd0);
      chk("rst_tuser", m_tuser[63:0], 64'd0);
      chk("rst_ready", {62'd0, cmd_ready, s_tready}, 64'd0);
      chk("rst_cnt", 64'(sent_cnt), 64'd0);
      cmd_valid = 1'b0;
      s_tvalid  = 1'b0;
      aresetn   = 1'b1;
      @(posedge clk);
      #1;

      for (int r = 0; r < 5; r++) begin
         send_cmd(vecs[r], hdr_ok);
         if (r == 0) chk("hdr_latency", 64'(hdr_ok), 64'd1);
         check_ctrl_pkt(vecs[r], 8'(r));
         repeat (2) @(negedge clk);
         chk("sent_cnt", 64'(sent_cnt), 64'(r + 1));
         @(posedge clk);
         #1;
      end

      // Both requesters held valid: strict alternation, data first after a control packet
      fork
         begin
            for (int c = 0; c < 4; c++) send_cmd(vecs[0], hdr_ok);
         end
         begin
            for (int p = 0; p < 4; p++) send_data(p, 2);
         end
      join
      wait_beats(16, "alt_beats");
      for (int p = 0; p < 8 && q_data.size() >= 2; p++) begin
         pop(d, k, u, l);
         is_ctrl = (bt(d, 12) == 8'h81) && (u[23:16] == 8'h5a);
         chk("alt_kind", 64'(is_ctrl), 64'(p % 2));
         if (is_ctrl) chk("alt_seq", 64'(bt(d, 53)), 64'(5 + p / 2));
         else         chk("alt_data0", 64'(d == mk_data(p / 2, 0)), 64'd1);
         pop(d, k, u, l);
         chk("alt_last", 64'(l), 64'd1);
         $display("ALT pkt=%0d kind=%s", p, is_ctrl ? "C" : "D");
      end
      @(posedge clk);
      #1;

      // Three-beat data packet under toggling backpressure
      tr_mode = 1;
      send_data(9, 3);
      wait_beats(3, "stall_beats");
      for (int b = 0; b < 3 && q_data.size() > 0; b++) begin
         pop(d, k, u, l);
         chk("data_beat", 64'(d == mk_data(9, b)), 64'd1);
         chk("data_keep", k, (b == 2) ? 64'h0f : '1);
         chk("data_user", u[63:0], 64'(32'hab00_0000 | 32'(9 << 8) | 32'(b)));
         chk("data_last", 64'(l), 64'(b == 2));
         $display("DATA pkt=9 beat=%0d", b);
      end
      repeat (4) @(negedge clk);
      chk("data_no_extra", 64'(q_data.size()), 64'd0);
      tr_mode = 0;
      @(posedge clk);
      #1;

      // Reset while the header beat is stalled
      tr_mode = 2;
      repeat (2) @(posedge clk);
      #1;
      send_cmd(vecs[0], hdr_ok);
      chk("stall_hdr_valid", 64'(hdr_ok), 64'd1);
      @(posedge clk);
      #3;
      aresetn = 1'b0;
      #1;
      chk("rst_mid_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_mid_tdata", 64'(m_tdata == 512'h0), 64'd1);
      repeat (2) @(negedge clk);
      q_data.delete();
      q_keep.delete();
      q_user.delete();
      q_last.delete();
      tr_mode = 0;
      aresetn = 1'b1;
      @(posedge clk);
      #1;
      send_cmd(vecs[0], hdr_ok);
      check_ctrl_pkt(vecs[0], 8'd0);
      repeat (2) @(negedge clk);
      chk("rst_after_cnt", 64'(sent_cnt), 64'd1);
      @(posedge clk);
      #1;

      // 255 more commands: 256 in total since reset, then the wrap to seq 0
      for (int c = 1; c < 256; c++) begin
         send_cmd(vecs[3], hdr_ok);
         check_ctrl_pkt(vecs[3], 8'(c));
      end
      repeat (2) @(negedge clk);
      chk("wrap_cnt_256", 64'(sent_cnt), 64'd256);
      @(posedge clk);
      #1;
      send_cmd(vecs[3], hdr_ok);
      check_ctrl_pkt(vecs[3], 8'd0);
      repeat (2) @(negedge clk);
      chk("wrap_cnt_257", 64'(sent_cnt), 64'd257);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
